// File: rtl/stream_buffer_fifo.sv
// stream_buffer_fifo: DEPTH-entry valid/ready stream buffer with registered
// output flags and an occupancy count for upstream throttling.
// Optional feature: define STREAM_BUFFER_READY_BYPASS_EN so that ready_o also
// follows ready_i when full. This allows push+pop on a full buffer, at the cost
// of a combinational ready_i->ready_o path.
module stream_buffer_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  testmode_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CNT_WIDTH-1:0]  usage_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int unsigned          PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
   logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
   logic [CNT_WIDTH-1:0]  usage_q, usage_d;
   logic                  push, pop;
   logic                  unused_testmode;

   assign unused_testmode = testmode_i;

   // Status flags decode from the occupancy register only.
   assign full_o  = (usage_q == CNT_FULL);
   assign empty_o = (usage_q == '0);
   assign valid_o = ~empty_o;
   assign usage_o = usage_q;

`ifdef STREAM_BUFFER_READY_BYPASS_EN
   // When full, a pop frees the read entry, and that same entry takes the push.
   assign ready_o = ~full_o | ready_i;
`else
   assign ready_o = ~full_o;
`endif

   assign push   = valid_i & ready_o;
   assign pop    = valid_o & ready_i;
   assign data_o = valid_o ? mem_q[rptr_q] : '0;

   // Next-state for pointers and occupancy; clear overrides push and pop.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      usage_d = usage_q;
      if (clr_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         usage_d = '0;
      end else begin
         if (push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_WIDTH'(1);
         end
         if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_WIDTH'(1);
         end
         if (push && !pop) begin
            usage_d = usage_q + CNT_WIDTH'(1);
         end else if (pop && !push) begin
            usage_d = usage_q - CNT_WIDTH'(1);
         end
      end
   end

   // Pointer and occupancy registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         usage_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         usage_q <= usage_d;
      end
   end

   // Storage array has no reset; a beat pushed during a clear is dropped.
   always_ff @(posedge clk_i) begin
      if (push && !clr_i) begin
         mem_q[wptr_q] <= data_i;
      end
   end

endmodule

// File: tb/tb_stream_buffer_fifo.sv
// Directed bench for stream_buffer_fifo: a vector table run on a DEPTH=3 instance,
// plus hand-written sequences for the async reset and the DEPTH=1 ready bypass.
module tb_stream_buffer_fifo;

`ifdef STREAM_BUFFER_READY_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DEPTH=3 instance
   logic       clr, valid_i, ready_i, valid_o, ready_o, full_o, empty_o;
   logic [7:0] data_i, data_o;
   logic [1:0] usage_o;

   // DEPTH=1 instance
   logic       v1_i, r1_i, v1_o, rd1_o, f1_o, e1_o;
   logic [7:0] d1_i, d1_o;
   logic [0:0] u1_o;

   stream_buffer_fifo #(.DATA_WIDTH(8), .DEPTH(3)) u_dut (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .testmode_i(1'b0),
      .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
      .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .usage_o(usage_o), .full_o(full_o), .empty_o(empty_o)
   );

   stream_buffer_fifo #(.DATA_WIDTH(8), .DEPTH(1)) u_d1 (
      .clk_i(clk), .rst_i(rst), .clr_i(1'b0), .testmode_i(1'b0),
      .valid_i(v1_i), .ready_o(rd1_o), .data_i(d1_i),
      .valid_o(v1_o), .ready_i(r1_i), .data_o(d1_o),
      .usage_o(u1_o), .full_o(f1_o), .empty_o(e1_o)
   );

   typedef struct {
      logic       v, r, c;
      logic [7:0] d;
      logic       ev, er;
      logic [7:0] ed;
      logic [1:0] eu;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic r, input logic c, input logic [7:0] d,
                      input logic ev, input logic er, input logic [7:0] ed,
                      input logic [1:0] eu);
      vec_t t;
      t.v = v; t.r = r; t.c = c; t.d = d;
      t.ev = ev; t.er = er; t.ed = ed; t.eu = eu;
      vecs.push_back(t);
   endtask

   task automatic chk3(input string tag, input int idx, input logic ev, input logic er,
                       input logic [7:0] ed, input logic [1:0] eu);
      chk({tag, ".valid"}, idx, 32'(valid_o), 32'(ev));
      chk({tag, ".ready"}, idx, 32'(ready_o), 32'(er));
      chk({tag, ".data"},  idx, 32'(data_o),  32'(ed));
      chk({tag, ".usage"}, idx, 32'(usage_o), 32'(eu));
      chk({tag, ".full"},  idx, 32'(full_o),  32'(eu == 2'd3));
      chk({tag, ".empty"}, idx, 32'(empty_o), 32'(eu == 2'd0));
   endtask

   initial begin
      int acc;
      int beats;
      logic e_rdy, e_vld;
      logic [7:0] e_dat;

      rst = 1'b1; clr = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
      v1_i = 1'b0; r1_i = 1'b0; d1_i = '0;

      // fill/drain with upstream holding 0x44 while full
      add(1,0,0,8'h11, 0,1,8'h00,0);
      add(1,0,0,8'h22, 1,1,8'h11,1);
      add(1,0,0,8'h33, 1,1,8'h11,2);
      add(1,0,0,8'h44, 1,0,8'h11,3);
      add(1,0,0,8'h44, 1,0,8'h11,3);
`ifdef STREAM_BUFFER_READY_BYPASS_EN
      add(1,1,0,8'h44, 1,1,8'h11,3);
      add(0,1,0,8'h00, 1,1,8'h22,3);
`else
      add(1,1,0,8'h44, 1,0,8'h11,3);
      add(1,1,0,8'h44, 1,1,8'h22,2);
`endif
      add(0,1,0,8'h00, 1,1,8'h33,2);
      add(0,1,0,8'h00, 1,1,8'h44,1);
      add(0,1,0,8'h00, 0,1,8'h00,0);
      // streaming 0..9
      for (int k = 0; k < 10; k++)
         add(1,1,0,8'(k), k > 0, 1, (k > 0) ? 8'(k - 1) : 8'h00, (k > 0) ? 2'd1 : 2'd0);
      add(0,1,0,8'h00, 1,1,8'h09,1);
      add(0,0,0,8'h00, 0,1,8'h00,0);
      // wrap-around: seven beats with irregular spacing
      add(1,0,0,8'hA0, 0,1,8'h00,0);
      add(0,0,0,8'h00, 1,1,8'hA0,1);
      add(1,1,0,8'hA1, 1,1,8'hA0,1);
      add(1,0,0,8'hA2, 1,1,8'hA1,1);
      add(1,0,0,8'hA3, 1,1,8'hA1,2);
      add(0,1,0,8'h00, 1,BYP,8'hA1,3);
      add(1,1,0,8'hA4, 1,1,8'hA2,2);
      add(0,1,0,8'h00, 1,1,8'hA3,2);
      add(1,1,0,8'hA5, 1,1,8'hA4,1);
      add(0,0,0,8'h00, 1,1,8'hA5,1);
      add(1,1,0,8'hA6, 1,1,8'hA5,1);
      add(0,1,0,8'h00, 1,1,8'hA6,1);
      add(0,0,0,8'h00, 0,1,8'h00,0);
      // clear with push+pop pending at usage 2; 0x77 must never appear
      add(1,0,0,8'h55, 0,1,8'h00,0);
      add(1,0,0,8'h66, 1,1,8'h55,1);
      add(1,1,1,8'h77, 1,1,8'h55,2);
      add(0,1,0,8'h00, 0,1,8'h00,0);
      add(0,1,0,8'h00, 0,1,8'h00,0);

      // reset state
      @(posedge clk); @(posedge clk); #1;
      chk3("rst", 0, 0, 1, 8'h00, 0);
      chk("rst.d1_ready", 0, 32'(rd1_o), 32'd1);
      chk("rst.d1_empty", 0, 32'(e1_o), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         valid_i = vecs[i].v; ready_i = vecs[i].r; clr = vecs[i].c; data_i = vecs[i].d;
         #1;
         chk3("vec", i, vecs[i].ev, vecs[i].er, vecs[i].ed, vecs[i].eu);
         @(posedge clk); #1;
      end
      valid_i = 0; ready_i = 0; clr = 0;

      // asynchronous reset with two beats held
      valid_i = 1; data_i = 8'h91; @(posedge clk); #1;
      data_i = 8'h92; @(posedge clk); #1;
      valid_i = 0; #1;
      chk3("arst_pre", 0, 1, 1, 8'h91, 2);
      #2 rst = 1'b1; #1;
      chk3("arst", 0, 0, 1, 8'h00, 0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk3("arst_post", 0, 0, 1, 8'h00, 0);

      // DEPTH=1: fill, then valid_i=ready_i=1 for 5 cycles
      v1_i = 1; d1_i = 8'hC0; #1;
      chk("d1fill.ready", 0, 32'(rd1_o), 32'd1);
      chk("d1fill.valid", 0, 32'(v1_o), 32'd0);
      @(posedge clk); #1;
      acc = 0; beats = 0;
      for (int k = 0; k < 5; k++) begin
         r1_i = 1; v1_i = 1; d1_i = 8'hC1 + 8'(acc);
         e_rdy = BYP ? 1'b1 : (k % 2 == 1);
         e_vld = BYP ? 1'b1 : (k % 2 == 0);
         e_dat = BYP ? 8'hC0 + 8'(k) : (e_vld ? 8'hC0 + 8'(k / 2) : 8'h00);
         #1;
         chk("d1.ready", k, 32'(rd1_o), 32'(e_rdy));
         chk("d1.valid", k, 32'(v1_o),  32'(e_vld));
         chk("d1.data",  k, 32'(d1_o),  32'(e_dat));
         chk("d1.full",  k, 32'(f1_o),  32'(e_vld));
         chk("d1.usage", k, 32'(u1_o),  32'(e_vld));
         if (v1_o) beats++;
         if (e_rdy) acc++;
         @(posedge clk); #1;
      end
      chk("d1.beats", 0, 32'(beats), BYP ? 32'd5 : 32'd3);
      v1_i = 0; r1_i = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
